// File: rtl/shift_subtract_divider.sv
// Sequential unsigned divider using the restoring shift-subtract algorithm.
// One quotient bit is produced per clock from a single shared trial-subtract
// datapath. A start/busy/done handshake lets the control unit stall while a
// division is in flight. Divide-by-zero completes in one cycle with a flag.
module shift_subtract_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  // The restoring algorithm keeps the partial remainder strictly below the
  // divisor, so its top bit is always zero; only the low WIDTH bits are stored
  // and the WIDTH+1-bit trial/difference carries the extra bit.
  logic [WIDTH-1:0] partial_rem;
  logic [WIDTH-1:0] shift_reg;    // dividend bits out at MSB, quotient bits in at LSB
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    count_next;

  // Trial-subtract datapath: one restoring iteration per cycle.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    trial      = {partial_rem, shift_reg[WIDTH-1]};
    diff       = trial - {1'b0, divisor_reg};
    borrow     = diff[WIDTH];
    rem_next   = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    shift_next = {shift_reg[WIDTH-2:0], ~borrow};
    count_next = count - 1'b1;
  end

  // Handshake outputs decode directly from the state, so reset clears them at once.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Control FSM, iteration registers and held result registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= S_IDLE;
      partial_rem <= '0;
      shift_reg   <= '0;
      divisor_reg <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            shift_reg   <= dividend;
            divisor_reg <= divisor;
            partial_rem <= '0;
            count       <= CW'(WIDTH);
            if (divisor == '0) begin
              // Zero divisor finishes immediately with saturated quotient.
              state       <= S_DONE;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          partial_rem <= rem_next;
          shift_reg   <= shift_next;
          count       <= count_next;
          if (count_next == '0) begin
            // Last iteration: publish results as DONE is entered.
            state       <= S_DONE;
            quotient    <= shift_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Bench for shift_subtract_divider: directed scenarios plus a random sweep.
// Stimulus pushes expected results into a scoreboard queue; a monitor pops
// and compares on every done pulse, including the expected done cycle.
module tb_shift_subtract_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  shift_subtract_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain integer division, saturated quotient for zero divisor.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.dbz = (b == 0);
    e.q   = (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    e.r   = (b == 0) ? a         : W'(int'(a) % int'(b));
    e.done_cyc = cyc + 1 + ((b == 0) ? 0 : W);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; counts busy cycles before it.
  task automatic wait_done(output int busy_n);
    bit seen = 0;
    busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    do_start(a, b);
    wait_done(n);
    check("busy_cycles", n, (b == 0) ? 0 : W);
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(mon_e.q));
        check("remainder", 32'(remainder), 32'(mon_e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
        check("done_cycle", cyc, mon_e.done_cyc);
        if (mon_e.b != 0) begin
          check("inv_product", 32'(quotient) * 32'(mon_e.b) + 32'(remainder), 32'(mon_e.a));
          check("inv_rem_lt_div", 32'(remainder < mon_e.b), 32'd1);
        end
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic and boundary divisions.
    run_one(16'd100, 16'd7);
    run_one(16'hFFFF, 16'd1);
    run_one(16'd3, 16'd10);
    run_one(16'hFFFF, 16'hFFFF);
    run_one(16'd5, 16'd0);

    // A second start while busy must be ignored.
    do_start(16'd1000, 16'd9);
    repeat (4) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    @(negedge clk);

    // Asynchronous reset mid-operation discards it without a done pulse.
    do_start(16'd1000, 16'd9);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    run_one(16'd50, 16'd5);

    // Back-to-back: second start issued in the done cycle of the first.
    do_start(16'd100, 16'd7);
    wait_done(n);
    do_start(16'd200, 16'd3);
    check("held_quotient", 32'(quotient), 32'd14);
    check("held_remainder", 32'(remainder), 32'd2);
    wait_done(n);
    @(negedge clk);

    // Random sweep, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom_range(0, 3));
        1:       rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      do_start(ra, rb);
      wait_done(n);
      check("rand_busy_cycles", n, (rb == 0) ? 0 : W);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
